// File: rtl/gfx_fetch_pkg.sv
// Shared defaults, FSM state encoding and a constant clog2 helper for the pixel fetcher.
package gfx_fetch_pkg;

  localparam int PF_DATA_W    = 32;
  localparam int PF_ADDR_W    = 17;
  localparam int PF_NUM_ADDRS = 115200;

  // state | meaning:  IDLE no fetching | RUN fetch and deal | DRAIN discard stale responses
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count; flush clears pointers and wins over push/pop.
module fetch_fifo
  import gfx_fetch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic [clog2(DEPTH):0]   count_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_fetch_mc.sv
// Multi-channel pixel fetcher: credit-limited sequential reads, FIFO buffering, round-robin deal.
// Defining FETCH_STATS_EN adds the underrun_cnt / frame_cnt statistics outputs.
module pixel_fetch_mc
  import gfx_fetch_pkg::*;
#(
  parameter int DATA_W    = PF_DATA_W,
  parameter int ADDR_W    = PF_ADDR_W,
  parameter int NUM_ADDRS = PF_NUM_ADDRS,
  parameter int DEPTH     = 8,
  parameter int NUM_CH    = 3
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_rts,
  input  logic              req_rtr,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_vld,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0] ch_rts,
  input  logic [NUM_CH-1:0] ch_rtr,
  output logic              frame_done,
  output logic              busy,
  output logic              err_ovf
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       underrun_cnt,
  output logic [15:0]       frame_cnt
`endif
);
  localparam int CW  = clog2(DEPTH) + 1;
  localparam int OW  = (NUM_ADDRS > 1) ? clog2(NUM_ADDRS) : 1;
  localparam int CHW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [OW-1:0]     fetch_off_q, pop_off_q;
  logic [CW-1:0]     outst_q, drop_q, inflight_d, fifo_cnt;
  logic [CHW-1:0]    cur_ch_q;
  logic              frame_done_q, err_ovf_q;
  logic              fifo_full, fifo_empty, credit_ok;
  logic              req_xfc, pop_xfc, rsp_keep, rsp_drop;

  function automatic logic [OW-1:0] off_inc(input logic [OW-1:0] off);
    return (off == OW'(NUM_ADDRS - 1)) ? '0 : off + OW'(1);
  endfunction

  function automatic logic [CHW-1:0] ch_inc(input logic [CHW-1:0] ch);
    return (ch == CHW'(NUM_CH - 1)) ? '0 : ch + CHW'(1);
  endfunction

  fetch_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push_i  (rsp_keep),
    .pop_i   (pop_xfc),
    .flush_i (start),
    .wdata_i (rsp_data),
    .rdata_o (out_data),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < (CW + 1)'(DEPTH);
  assign req_rts   = (state_q == ST_RUN) & credit_ok;
  assign req_xfc   = req_rts & req_rtr;
  assign rsp_keep  = rsp_vld & (drop_q == '0);
  assign rsp_drop  = rsp_vld & (drop_q != '0);
  assign req_addr  = base_q + ADDR_W'(fetch_off_q);

  always_comb begin
    ch_rts = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_rts[k] = ~fifo_empty & (int'(cur_ch_q) == k);
    end
  end

  // A handover coinciding with start is void: the FIFO is flushed that cycle.
  assign pop_xfc = (|(ch_rts & ch_rtr)) & ~start;

  // Everything still in flight once this cycle settles is stale after a start.
  assign inflight_d = outst_q + drop_q + CW'(req_xfc) - CW'(rsp_vld);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_RUN:   if (stop) state_d = ST_IDLE;
      ST_DRAIN: if (drop_q == '0) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (start) state_d = (inflight_d == '0) ? ST_RUN : ST_DRAIN;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      base_q       <= '0;
      fetch_off_q  <= '0;
      pop_off_q    <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      cur_ch_q     <= '0;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      frame_done_q <= pop_xfc & (pop_off_q == OW'(NUM_ADDRS - 1));
      err_ovf_q    <= err_ovf_q | (rsp_vld & fifo_full);
      if (start) begin
        base_q      <= base_addr;
        fetch_off_q <= '0;
        pop_off_q   <= '0;
        cur_ch_q    <= '0;
        outst_q     <= '0;
        drop_q      <= inflight_d;
      end else begin
        if (req_xfc) fetch_off_q <= off_inc(fetch_off_q);
        if (pop_xfc) begin
          pop_off_q <= off_inc(pop_off_q);
          cur_ch_q  <= ch_inc(cur_ch_q);
        end
        outst_q <= outst_q + CW'(req_xfc) - CW'(rsp_keep);
        drop_q  <= drop_q - CW'(rsp_drop);
      end
    end
  end

  assign frame_done = frame_done_q;
  assign err_ovf    = err_ovf_q;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      underrun_cnt <= '0;
      frame_cnt    <= '0;
    end else if (start) begin
      underrun_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      if ((state_q == ST_RUN) && fifo_empty && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + 32'd1;
      if (frame_done_q) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  // Statistics build option off: no counters, datapath unchanged.
`endif

endmodule
